ram_responder: RTL and testbench

- Responder end of the cache-to-memory request interface: a single-port word memory with a configurable multi-cycle access latency.
- A request is the word on data/address/mode; a new request is recognised when those inputs change. response is held high while an access is in progress.
- Sits below the direct-mapped cache as its backing store. Also usable standalone as slow main memory in benches.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_array.sv | 28 ++
 rtl/ram_responder.sv | 121 ++++++++++++
 tb/tb_ram_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and defaults for the ram_responder slice.
// Provides the FSM state enum, default sizes and mode encodings.
package ram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int SIZE_RAM_DEF  = 4096;
  localparam int ADDR_BITS_DEF = 12;
  localparam int WORD_W        = 32;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-port word array with registered read.
// Ports: clk, i_we, i_addr, i_wdata (write side), o_rdata (registered read).
module ram_array
  import ram_pkg::*;
#(
  parameter int SIZE_RAM  = SIZE_RAM_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [WORD_W-1:0]    i_wdata,
  output logic [WORD_W-1:0]    o_rdata
);

  logic [WORD_W-1:0] r_mem [SIZE_RAM];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Responder side of the cache-to-memory interface: word memory with
// a fixed multi-cycle access latency and saturating access counters.
// Ports: clk, rst (async, active-high); request data/address/mode;
// out (read data), response (busy), rd_count/wr_count (statistics).
module ram_responder
  import ram_pkg::*;
#(
  parameter int SIZE_RAM  = SIZE_RAM_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int LATENCY   = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data,
  input  logic [31:0]      address,
  input  logic             mode,
  output logic [31:0]      out,
  output logic             response,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_lat_addr;
  logic [31:0]            r_lat_data;
  logic                   r_lat_mode;
  logic [31:0]            r_out;
  logic                   r_resp;
  logic [CNT_W-1:0]       r_rd_cnt;
  logic [CNT_W-1:0]       r_wr_cnt;

  logic [ADDR_BITS-1:0]   w_addr;
  logic [31-ADDR_BITS:0]  w_unused_addr_hi;
  logic                   w_new;
  logic                   w_done;
  logic                   w_we;
  logic [ADDR_BITS-1:0]   w_ram_addr;
  logic [31:0]            w_rdata;

  assign w_addr           = address[ADDR_BITS-1:0];
  assign w_unused_addr_hi = address[31:ADDR_BITS];

  assign w_new = (w_addr != r_lat_addr) ||
                 (data != r_lat_data) ||
                 (mode != r_lat_mode);

  assign w_done = (r_state == BUSY) && (r_cnt == 8'd0);
  assign w_we   = w_done && (r_lat_mode == MODE_WRITE);

  // While idle the array tracks the incoming address so the registered
  // read already holds the target word by the completion edge, even
  // when LATENCY is 1. Memory cannot change while busy.
  assign w_ram_addr = (r_state == IDLE) ? w_addr : r_lat_addr;

  ram_array #(
    .SIZE_RAM  (SIZE_RAM),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_lat_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_lat_addr <= '0;
      r_lat_data <= 32'd0;
      r_lat_mode <= MODE_READ;
      r_out      <= 32'd0;
      r_resp     <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_new) begin
            r_lat_addr <= w_addr;
            r_lat_data <= data;
            r_lat_mode <= mode;
            r_resp     <= 1'b1;
            r_cnt      <= LAT_M1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            if (r_lat_mode == MODE_WRITE) begin
              if (~&r_wr_cnt) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
              end
            end else begin
              r_out <= w_rdata;
              if (~&r_rd_cnt) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
              end
            end
            r_resp  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out      = r_out;
  assign response = r_resp;
  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder with a behavioural model.
// Second instance covers LATENCY=1 and counter saturation.
module tb_ram_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data = 32'd0;
  logic [31:0] address = 32'd0;
  logic        mode = 1'b0;
  wire  [31:0] out;
  wire         response;
  wire  [15:0] rd_count;
  wire  [15:0] wr_count;

  logic [31:0] d1 = 32'd0;
  logic [31:0] a1 = 32'd0;
  logic        m1 = 1'b0;
  wire  [31:0] out1;
  wire         resp1;
  wire  [1:0]  rd1;
  wire  [1:0]  wr1;

  always #5 clk = ~clk;

  ram_responder #(
    .SIZE_RAM(4096), .ADDR_BITS(12), .LATENCY(LAT), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .address(address),
    .mode(mode), .out(out), .response(response),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  ram_responder #(
    .SIZE_RAM(4096), .ADDR_BITS(12), .LATENCY(1), .CNT_W(2)
  ) dut1 (
    .clk(clk), .rst(rst), .data(d1), .address(a1),
    .mode(m1), .out(out1), .response(resp1),
    .rd_count(rd1), .wr_count(wr1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: remaining busy cycles, latched request,
  // memory as a sparse map and plain integer statistics.
  int          m_left  = 0;
  logic [11:0] m_la    = 12'd0;
  logic [31:0] m_ld    = 32'd0;
  logic        m_lm    = 1'b0;
  logic [31:0] m_out   = 32'd0;
  bit          m_known = 1'b1;
  int          m_rd    = 0;
  int          m_wr    = 0;
  logic [31:0] mm [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  = 0;
      m_la    = 12'd0;
      m_ld    = 32'd0;
      m_lm    = 1'b0;
      m_out   = 32'd0;
      m_known = 1'b1;
      m_rd    = 0;
      m_wr    = 0;
    end else if (m_left == 0) begin
      if (address[11:0] != m_la || data != m_ld || mode != m_lm) begin
        m_la   = address[11:0];
        m_ld   = data;
        m_lm   = mode;
        m_left = LAT;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_lm) begin
          mm[int'(m_la)] = m_ld;
          if (m_wr < 65535) m_wr++;
        end else begin
          if (mm.exists(int'(m_la))) begin
            m_out   = mm[int'(m_la)];
            m_known = 1'b1;
          end else begin
            m_known = 1'b0;
          end
          if (m_rd < 65535) m_rd++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_response", 32'(response), 32'(m_left != 0));
    chk("m_rd_count", 32'(rd_count), 32'(m_rd));
    chk("m_wr_count", 32'(wr_count), 32'(m_wr));
    if (m_known) chk("m_out", out, m_out);
  end

  // Counts negedges with response high until it drops; bounded.
  task automatic wait_low(input bit sel, output int hi);
    bit done;
    int k;
    logic r;
    hi   = 0;
    done = 1'b0;
    k    = 0;
    while (!done && k < LAT + 20) begin
      @(negedge clk);
      #1;
      r = sel ? resp1 : response;
      if (r) hi++;
      else if (hi > 0) done = 1'b1;
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: response never completed (sel %0d)", sel);
    end
  endtask

  task automatic access(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic m,
                        output int hi);
    @(negedge clk);
    #2;
    address = a;
    data    = d;
    mode    = m;
    wait_low(1'b0, hi);
  endtask

  initial begin
    int hi;
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_resp", 32'(response), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_rd", 32'(rd_count), 32'd0);
    chk("rst_wr", 32'(wr_count), 32'd0);
    #1 rst = 1'b0;

    access(32'd5, 32'hDEADBEEF, 1'b1, hi);
    chk("wr_latency", 32'(hi), 32'd4);
    chk("wr_count1", 32'(wr_count), 32'd1);
    chk("wr_out_held", out, 32'd0);

    access(32'd5, 32'd0, 1'b0, hi);
    chk("rd_latency", 32'(hi), 32'd4);
    chk("rd_data5", out, 32'hDEADBEEF);
    chk("rd_count1", 32'(rd_count), 32'd1);

    access(32'd4096 + 32'd7, 32'h11, 1'b1, hi);
    access(32'd7, 32'd0, 1'b0, hi);
    chk("wrap_data", out, 32'h11);

    access(32'd9, 32'h22, 1'b1, hi);
    access(32'd10, 32'h44, 1'b1, hi);

    @(negedge clk);
    #2;
    address = 32'd5;
    data    = 32'd0;
    mode    = 1'b0;
    repeat (2) @(negedge clk);
    #2 address = 32'd9;
    wait_low(1'b0, hi);
    chk("busy_chg_first", out, 32'hDEADBEEF);
    wait_low(1'b0, hi);
    chk("busy_chg_lat", 32'(hi), 32'd4);
    chk("busy_chg_second", out, 32'h22);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("hold_resp", 32'(response), 32'd0);
      chk("hold_rd", 32'(rd_count), 32'd4);
      chk("hold_wr", 32'(wr_count), 32'd4);
    end

    @(negedge clk);
    #2;
    address = 32'd10;
    data    = 32'h33;
    mode    = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst     = 1'b1;
    address = 32'd0;
    data    = 32'd0;
    mode    = 1'b0;
    #1;
    chk("abort_resp", 32'(response), 32'd0);
    chk("abort_out", out, 32'd0);
    chk("abort_rd", 32'(rd_count), 32'd0);
    chk("abort_wr", 32'(wr_count), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    access(32'd10, 32'd0, 1'b0, hi);
    chk("abort_mem_kept", out, 32'h44);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      a1 = 32'd3;
      d1 = 32'(i + 5);
      m1 = 1'b1;
      wait_low(1'b1, hi);
      chk("lat1_high", 32'(hi), 32'd1);
    end
    chk("lat1_wr_sat", 32'(wr1), 32'd3);
    @(negedge clk);
    #2;
    d1 = 32'd0;
    m1 = 1'b0;
    wait_low(1'b1, hi);
    chk("lat1_rd_high", 32'(hi), 32'd1);
    chk("lat1_rd_data", out1, 32'd9);
    chk("lat1_rd_cnt", 32'(rd1), 32'd1);

    for (int i = 0; i < 16; i++) begin
      access(32'(i), 32'(i) * 32'h01010101 ^ 32'hA5, 1'b1, hi);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if ($urandom_range(2) == 0) begin
        address = $urandom_range(15) + 32'($urandom_range(1)) * 32'd4096;
        data    = $urandom_range(3);
        mode    = 1'($urandom_range(1));
      end
    end
    repeat (LAT + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
